// File: rtl/button_event_decoder.sv
// Debounced button level to one-cycle short/long/double/repeat event pulses.
// All timing is counted in clk cycles; every output is registered.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned DCLICK_CYCLES = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_press
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HELD
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST =
        (REPEAT_CYCLES > 0) ? CNT_W'(REPEAT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic             REPEAT_EN   = (REPEAT_CYCLES > 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             pressed_q, pressed_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             repeat_q, repeat_d;
    logic             rise;

    assign rise = btn_db & ~prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        prev_d    = btn_db;
        pressed_d = btn_db;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                // The long edge fires even if the button is low on that very edge
                if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = btn_db ? HELD : IDLE;
                    cnt_d   = '0;
                end else if (!btn_db) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end
            end
            WAIT2: begin
                if (cnt_q == DCLICK_LAST) begin
                    short_d = 1'b1;
                    state_d = rise ? PRESS1 : IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end
            end
            PRESS2: begin
                if (!btn_db) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            HELD: begin
                if (!btn_db) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (REPEAT_EN && cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // prev resets high so a button held through reset is not seen as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b1;
            pressed_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            pressed_q <= pressed_d;
            short_q   <= short_d;
            long_q    <= long_d;
            double_q  <= double_d;
            repeat_q  <= repeat_d;
        end
    end

    assign pressed      = pressed_q;
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign repeat_press = repeat_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed vector bench for button_event_decoder with LONG=8, DCLICK=5, REPEAT=3.
// Vectors hold the button level per edge and the outputs expected right after it.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_db = 1'b0;
    logic pressed, short_press, long_press, double_press, repeat_press;

    int checks = 0;
    int errors = 0;

    // event nibble order: {short, long, double, repeat}
    localparam logic [3:0] N  = 4'b0000;
    localparam logic [3:0] S  = 4'b1000;
    localparam logic [3:0] L  = 4'b0100;
    localparam logic [3:0] D  = 4'b0010;
    localparam logic [3:0] RP = 4'b0001;

    typedef struct {
        logic       btn;
        logic [3:0] ev;
        string      name;
    } vec_t;

    vec_t vecs[$];

    button_event_decoder #(
        .LONG_CYCLES  (8),
        .DCLICK_CYCLES(5),
        .REPEAT_CYCLES(3),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_db      (btn_db),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .repeat_press(repeat_press)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {pressed, short_press, long_press, double_press, repeat_press};
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx %0d got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic [3:0] ev,
                        input string nm, input int idx);
        @(negedge clk);
        btn_db = b;
        @(posedge clk);
        #1;
        check(nm, idx, outs(), {b, ev});
    endtask

    function automatic void add(input logic b, input logic [3:0] ev,
                                input string nm);
        vec_t v;
        v.btn  = b;
        v.ev   = ev;
        v.name = nm;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(input logic b, input int n,
                                  input string nm);
        for (int i = 0; i < n; i++) add(b, N, nm);
    endfunction

    initial begin
        // short press: released at idx 3, short 5 edges later
        add_n(0, 2, "idle");
        add_n(1, 3, "short");
        add_n(0, 5, "short");
        add(0, S, "short");
        add_n(0, 3, "short");
        // long + repeats, release on a repeat edge is silent
        add_n(1, 8, "long");
        add(1, L, "long");
        add_n(1, 2, "long");
        add(1, RP, "long");
        add_n(1, 2, "long");
        add(1, RP, "long");
        add_n(1, 2, "long");
        add(1, RP, "long");
        add_n(1, 2, "long");
        add_n(0, 4, "long");
        // double press
        add_n(1, 2, "dbl");
        add_n(0, 2, "dbl");
        add_n(1, 2, "dbl");
        add(0, D, "dbl");
        add_n(0, 7, "dbl");
        // rise exactly on window end: short then fresh press
        add_n(1, 2, "edge5");
        add_n(0, 5, "edge5");
        add(1, S, "edge5");
        add(1, N, "edge5");
        add_n(0, 5, "edge5");
        add(0, S, "edge5");
        add_n(0, 2, "edge5");
        // release on the long edge itself
        add_n(1, 8, "long_rel");
        add(0, L, "long_rel");
        add_n(0, 7, "long_rel");
        // release one edge before long
        add_n(1, 7, "pre_long");
        add_n(0, 5, "pre_long");
        add(0, S, "pre_long");
        add_n(0, 2, "pre_long");
        // 2nd rise on last window edge
        add_n(1, 2, "win_last");
        add_n(0, 4, "win_last");
        add_n(1, 3, "win_last");
        add(0, D, "win_last");
        add_n(0, 6, "win_last");

        #12;
        check("reset", 0, outs(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].btn, vecs[i].ev, vecs[i].name, i);

        // held across reset: async clear, then no event until re-press
        step(1, N, "hold_rst", 0);
        step(1, N, "hold_rst", 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr", 0, outs(), 5'b00000);
        @(posedge clk);
        #1;
        check("in_reset", 0, outs(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1, N, "hold_rst", i + 2);
        for (int i = 0; i < 3; i++) step(0, N, "hold_rel", i);
        step(1, N, "re_press", 0);
        step(1, N, "re_press", 1);
        for (int i = 0; i < 5; i++) step(0, N, "re_press", i + 2);
        step(0, S, "re_press", 7);
        step(0, N, "re_press", 8);

        // reset while waiting for a second press drops the short
        step(1, N, "wait2_rst", 0);
        step(1, N, "wait2_rst", 1);
        step(0, N, "wait2_rst", 2);
        step(0, N, "wait2_rst", 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("wait2_clr", 0, outs(), 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(0, N, "wait2_after", i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
